// File: rtl/score_digit_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// score_pkg
//   Shared constants, types and helpers for the on-screen score field.
//   DIGIT_WIDTH/DIGIT_HEIGHT give the glyph cell size in pixels, and
//   DIGIT_W_LOG2 is the shift that turns a field column into a digit index.
// -----------------------------------------------------------------------------
package score_pkg;

  localparam int DIGIT_WIDTH  = 16;
  localparam int DIGIT_HEIGHT = 32;
  localparam int DIGIT_W_LOG2 = 4;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    PENDING
  } sched_state_t;

  // Double-dabble correction: a nibble of 5 or more would overflow past 9
  // once doubled, so it is pre-biased by 3 before the shift.
  function automatic bcd_digit_t add3_adjust(input bcd_digit_t d);
    return (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/score_digit_scheduler_if.sv
// -----------------------------------------------------------------------------
// score_digit_scheduler_if
//   Valid/ready score handshake between a score source and the scheduler.
//   scoreValid : source offers a score
//   score      : binary score, SCORE_WIDTH bits
//   scoreReady : scheduler can accept a score this cycle
//   master = score source, slave = scheduler.
// -----------------------------------------------------------------------------
interface score_digit_scheduler_if #(
  parameter int SCORE_WIDTH = 16
);
  logic                   scoreValid;
  logic [SCORE_WIDTH-1:0] score;
  logic                   scoreReady;

  modport master (output scoreValid, output score, input  scoreReady);
  modport slave  (input  scoreValid, input  score, output scoreReady);
endinterface

// File: rtl/score_digit_scheduler_bcd.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_serial
//   Serial shift-add-3 binary to BCD converter, one bit per clock.
//   clk, resetN : clock, asynchronous active-low reset
//   start_i     : load bin_i, clear accumulator, arm SCORE_WIDTH shifts
//   bin_i       : binary value to convert
//   bcd_o       : BCD accumulator, most significant digit in the top nibble
//   done_o      : high during the cycle whose closing edge makes the last shift
// -----------------------------------------------------------------------------
module bin_to_bcd_serial
  import score_pkg::*;
#(
  parameter int SCORE_WIDTH = 16,
  parameter int NUM_DIGITS  = 5
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    start_i,
  input  logic [SCORE_WIDTH-1:0]  bin_i,
  output logic [4*NUM_DIGITS-1:0] bcd_o,
  output logic                    done_o
);

  localparam int CNT_W = $clog2(SCORE_WIDTH + 1);

  logic [SCORE_WIDTH-1:0]  bin_q, bin_d;
  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      bcd_adj[4*i +: 4] = add3_adjust(bcd_q[4*i +: 4]);
    end
    if (start_i) begin
      bin_d = bin_i;
      bcd_d = '0;
      cnt_d = CNT_W'(SCORE_WIDTH);
    end else if (cnt_q != '0) begin
      bcd_d = {bcd_adj[4*NUM_DIGITS-2:0], bin_q[SCORE_WIDTH-1]};
      bin_d = {bin_q[SCORE_WIDTH-2:0], 1'b0};
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      // NOTE: non-blocking assignments for all state so every register
      // samples the pre-edge value regardless of statement order.
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  assign bcd_o  = bcd_q;
  assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/score_digit_scheduler.sv
// -----------------------------------------------------------------------------
// score_digit_scheduler
//   Accepts a binary score, converts it to BCD serially, commits the digits
//   on the next frame boundary after conversion, and maps each pixel to the
//   digit code and intra-glyph offsets for the bitmap renderer.
//   clk, resetN     : pixel clock, asynchronous active-low reset
//   pixelX, pixelY  : current pixel position
//   startOfFrame    : one-cycle frame-start pulse, commit point
//   score_bus       : valid/ready score handshake (slave side)
//   busy            : conversion or commit pending
//   offsetX/offsetY : position inside the current glyph (registered)
//   number          : digit code of the current cell (registered)
//   insideRectangle : pixel lies in a drawn digit cell (registered)
//   Optional: SCORE_LEADING_ZERO_BLANK_EN blanks leading zero digits.
// -----------------------------------------------------------------------------
module score_digit_scheduler
  import score_pkg::*;
#(
  parameter int          NUM_DIGITS  = 5,
  parameter int          SCORE_WIDTH = 16,
  parameter logic [10:0] TOP_LEFT_X  = 11'd16,
  parameter logic [10:0] TOP_LEFT_Y  = 11'd16
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic [10:0]              pixelX,
  input  logic [10:0]              pixelY,
  input  logic                     startOfFrame,
  score_digit_scheduler_if.slave   score_bus,
  output logic                     busy,
  output logic [10:0]              offsetX,
  output logic [10:0]              offsetY,
  output logic [3:0]               number,
  output logic                     insideRectangle
);

  localparam logic [10:0] FIELD_W = 11'(DIGIT_WIDTH * NUM_DIGITS);
  localparam logic [10:0] FIELD_H = 11'(DIGIT_HEIGHT);
  localparam int          IDX_W   = 11 - DIGIT_W_LOG2;

  sched_state_t state_q, state_d;
  logic         accept, commit, conv_done;
  logic [4*NUM_DIGITS-1:0] bcd;

  assign accept = (state_q == IDLE) && score_bus.scoreValid;
  assign commit = (state_q == PENDING) && startOfFrame;

  bin_to_bcd_serial #(
    .SCORE_WIDTH (SCORE_WIDTH),
    .NUM_DIGITS  (NUM_DIGITS)
  ) u_bcd (
    .clk     (clk),
    .resetN  (resetN),
    .start_i (accept),
    .bin_i   (score_bus.score),
    .bcd_o   (bcd),
    .done_o  (conv_done)
  );

  // ---------------- scheduler FSM ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = CONVERT;
      CONVERT: if (conv_done) state_d = PENDING;
      PENDING: if (commit)    state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  assign score_bus.scoreReady = (state_q == IDLE);
  assign busy                 = (state_q != IDLE);

  // ---------------- displayed digits ----------------
  // Index 0 is the leftmost (most significant) digit, i.e. the top nibble.
  bcd_digit_t [NUM_DIGITS-1:0] disp_q;
  logic       [NUM_DIGITS-1:0] blank_q;

`ifdef SCORE_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_d;
  always_comb begin
    logic leading;
    leading = 1'b1;
    blank_d = '0;
    for (int i = 0; i < NUM_DIGITS - 1; i++) begin
      leading    = leading && (bcd[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
      blank_d[i] = leading;
    end
  end
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      // NOTE: the digit bank is a handful of flops that must read as zero
      // after reset, so it is reset like ordinary state, not left as RAM.
      disp_q  <= '0;
      blank_q <= '0;
    end else if (commit) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        disp_q[i] <= bcd[4*(NUM_DIGITS-1-i) +: 4];
      end
`ifdef SCORE_LEADING_ZERO_BLANK_EN
      blank_q <= blank_d;
`else
      blank_q <= '0;
`endif
    end
  end

  // ---------------- pixel mapping ----------------
  logic [10:0]      dx, dy;
  logic [IDX_W-1:0] idx;
  logic             in_field, cell_blank;
  logic [3:0]       num_d;

  always_comb begin
    dx  = pixelX - TOP_LEFT_X;
    dy  = pixelY - TOP_LEFT_Y;
    idx = dx[10:DIGIT_W_LOG2];
    // The lower-bound compare guards the wrapped subtraction.
    in_field = (pixelX >= TOP_LEFT_X) && (dx < FIELD_W) &&
               (pixelY >= TOP_LEFT_Y) && (dy < FIELD_H);
    num_d      = 4'd0;
    cell_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        num_d      = disp_q[i];
        cell_blank = blank_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      offsetX         <= '0;
      offsetY         <= '0;
      number          <= '0;
      insideRectangle <= 1'b0;
    end else begin
      offsetX         <= {7'd0, dx[DIGIT_W_LOG2-1:0]};
      offsetY         <= dy;
      number          <= num_d;
      insideRectangle <= in_field && !cell_blank;
    end
  end

endmodule

// File: tb/tb_score_digit_scheduler.sv
module tb_score_digit_scheduler;

  localparam int TLX = 16;
  localparam int TLY = 16;
  localparam int ND  = 5;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [10:0] pixelX = '0;
  logic [10:0] pixelY = '0;
  logic        startOfFrame = 1'b0;
  logic        busy;
  logic [10:0] offsetX, offsetY;
  logic [3:0]  number;
  logic        insideRectangle;

  int total = 0;
  int bad   = 0;
  int shown_score = 0;   // score the model believes is on screen
  int p10[ND] = '{10000, 1000, 100, 10, 1};

  score_digit_scheduler_if #(.SCORE_WIDTH(16)) sbus ();

  score_digit_scheduler #(
    .NUM_DIGITS  (ND),
    .SCORE_WIDTH (16),
    .TOP_LEFT_X  (11'd16),
    .TOP_LEFT_Y  (11'd16)
  ) dut (
    .clk             (clk),
    .resetN          (resetN),
    .pixelX          (pixelX),
    .pixelY          (pixelY),
    .startOfFrame    (startOfFrame),
    .score_bus       (sbus),
    .busy            (busy),
    .offsetX         (offsetX),
    .offsetY         (offsetY),
    .number          (number),
    .insideRectangle (insideRectangle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Offer a score and hold valid until the handshake edge (bounded).
  task automatic send_score(input int s);
    logic taken;
    taken = 1'b0;
    sbus.scoreValid = 1'b1;
    sbus.score      = 16'(s);
    for (int i = 0; i < 50 && !taken; i++) begin
      taken = sbus.scoreReady;
      tick();
    end
    sbus.scoreValid = 1'b0;
    check("accept_timeout", 32'(taken), 32'd1);
  endtask

  task automatic pulse_sof();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  function automatic int model_digit(input int s, input int i);
    return (s / p10[i]) % 10;
  endfunction

  function automatic bit model_blank(input int s, input int i);
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    return (i < ND - 1) && (s < p10[i]);
`else
    return 1'b0;
`endif
  endfunction

  // Drive one pixel, wait one clock, compare against the arithmetic model.
  task automatic probe(input string tag, input int x, input int y);
    int  idx;
    bit  in_x, in_y, exp_in;
    pixelX = 11'(x);
    pixelY = 11'(y);
    tick();
    in_x   = (x >= TLX) && (x < TLX + 16 * ND);
    in_y   = (y >= TLY) && (y < TLY + 32);
    idx    = in_x ? (x - TLX) / 16 : 0;
    exp_in = in_x && in_y && !model_blank(shown_score, idx);
    check({tag, "_offx"},   32'(offsetX), 32'((x - TLX) & 15));
    check({tag, "_offy"},   32'(offsetY), 32'((y - TLY) & 2047));
    check({tag, "_inside"}, 32'(insideRectangle), 32'(exp_in));
    if (exp_in) check({tag, "_num"}, 32'(number), 32'(model_digit(shown_score, idx)));
  endtask

  task automatic probe_cells(input string tag);
    for (int i = 0; i < ND; i++) probe(tag, TLX + 16 * i + 3, TLY + 10);
  endtask

  initial begin
    sbus.scoreValid = 1'b0;
    sbus.score      = '0;

    // Reset values.
    #12;
    check("rst_ready",  32'(sbus.scoreReady), 32'd1);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_offx",   32'(offsetX), 32'd0);
    check("rst_offy",   32'(offsetY), 32'd0);
    check("rst_num",    32'(number), 32'd0);
    check("rst_inside", 32'(insideRectangle), 32'd0);
    resetN = 1'b1;
    tick();

    // Reset mid-conversion discards the conversion.
    send_score(999);
    wait_cycles(4);
    check("conv_busy", 32'(busy), 32'd1);
    resetN = 1'b0;
    #1;
    check("midrst_ready",  32'(sbus.scoreReady), 32'd1);
    check("midrst_busy",   32'(busy), 32'd0);
    check("midrst_num",    32'(number), 32'd0);
    check("midrst_inside", 32'(insideRectangle), 32'd0);
    tick();
    resetN = 1'b1;
    shown_score = 0;
    probe_cells("zero");

    // 1234 committed on a frame pulse.
    send_score(1234);
    wait_cycles(20);
    check("pend_busy", 32'(busy), 32'd1);
    pulse_sof();
    check("commit_busy", 32'(busy), 32'd0);
    shown_score = 1234;
    probe("p37_7", TLX + 37, TLY + 7);
    probe("right_edge_out", TLX + 80, TLY);
    probe("left_edge_out", TLX - 1, TLY);
    probe("last_in", TLX + 79, TLY + 31);
    probe("below_out", TLX, TLY + 32);

    // Frame pulse during conversion has no effect.
    send_score(65535);
    wait_cycles(3);
    pulse_sof();
    check("early_sof_busy", 32'(busy), 32'd1);
    probe_cells("old_digits");
    wait_cycles(12);
    check("pend2_busy", 32'(busy), 32'd1);
    probe_cells("still_old");
    pulse_sof();
    check("commit2_busy", 32'(busy), 32'd0);
    shown_score = 65535;
    probe_cells("max");

    // A score offered while busy is ignored.
    send_score(7);
    wait_cycles(2);
    sbus.scoreValid = 1'b1;
    sbus.score      = 16'd42;
    for (int i = 0; i < 5; i++) begin
      check("busy_not_ready", 32'(sbus.scoreReady), 32'd0);
      tick();
    end
    sbus.scoreValid = 1'b0;
    wait_cycles(15);
    pulse_sof();
    check("commit3_busy", 32'(busy), 32'd0);
    shown_score = 7;
    probe_cells("seven");

    // Zero: rightmost cell always drawn.
    send_score(0);
    wait_cycles(20);
    pulse_sof();
    shown_score = 0;
    probe_cells("zero2");

    // Random scores and random pixels around the field.
    for (int n = 0; n < 6; n++) begin
      int s;
      s = int'($urandom_range(0, 65535));
      send_score(s);
      wait_cycles(18);
      pulse_sof();
      shown_score = s;
      for (int k = 0; k < 8; k++) begin
        probe("rnd", TLX - 8 + int'($urandom_range(0, 100)),
                     TLY - 4 + int'($urandom_range(0, 40)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
